// File: rtl/mips_multicycle_core_if.sv
// Program-load bus into the core's instruction memory.
// Driven by a loader (bench, boot ROM) while the core is idle or halted.
interface mips_multicycle_core_if #(
    parameter int IMEM_AW = 4,
    parameter int INSTR_W = 12
);
    logic               imem_we;
    logic [IMEM_AW-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    modport master (output imem_we, imem_addr, imem_wdata);
    modport slave  (input  imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle R/I-type MIPS-style core: FETCH/DECODE/EXEC/WB,
// $0 hardwired to zero, BEQ, HALT, program-load port and debug taps.
module mips_multicycle_core #(
    parameter int DATA_W  = 4,
    parameter int REG_AW  = 2,
    parameter int IMM_W   = 4,
    parameter int IMEM_AW = 4,
    parameter int INSTR_W = 4 + 2*REG_AW + IMM_W,
    parameter int CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    mips_multicycle_core_if.slave imem,
    input  logic [REG_AW-1:0]    dbg_raddr,
    output logic [DATA_W-1:0]    dbg_rdata,
    output logic [IMEM_AW-1:0]   pc,
    output logic [INSTR_W-1:0]   ir,
    output logic [DATA_W-1:0]    writedata,
    output logic                 wb_valid,
    output logic                 busy,
    output logic                 halted,
    output logic [CNT_W-1:0]     instr_count
);
    localparam int RF_N = 2**REG_AW;
    localparam int IM_N = 2**IMEM_AW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [INSTR_W-1:0] imem_q [IM_N];
    logic [DATA_W-1:0]  regs_q [RF_N];

    logic [2:0]         state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]  res_q, res_d, wd_q, wd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rf_we;

    logic               ityp;
    logic [2:0]         op;
    logic [REG_AW-1:0]  rd, rs, rt;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W-1:0]  sext_d;
    logic [IMEM_AW-1:0] sext_pc;
    logic [DATA_W-1:0]  alu_r;
    logic               idle_like;

    assign ityp    = ir_q[INSTR_W-1];
    assign op      = ir_q[INSTR_W-2 -: 3];
    assign rd      = ir_q[2*REG_AW+IMM_W-1 -: REG_AW];
    assign rs      = ir_q[REG_AW+IMM_W-1 -: REG_AW];
    assign imm     = ir_q[IMM_W-1:0];
    assign rt      = imm[IMM_W-1 -: REG_AW];
    assign sext_d  = DATA_W'($signed(imm));
    assign sext_pc = IMEM_AW'($signed(imm));

    assign idle_like = (state_q == S_IDLE) || (state_q == S_HALT);

    // ALU on the operands latched in DECODE
    always_comb begin
        alu_r = '0;
        case (op)
            3'b000:  alu_r = a_q & b_q;
            3'b001:  alu_r = a_q + b_q;
            3'b010:  alu_r = a_q - b_q;
            3'b011:  alu_r = DATA_W'($signed(a_q) < $signed(b_q));
            3'b100:  alu_r = a_q | b_q;
            3'b101:  alu_r = a_q ^ b_q;
            default: alu_r = '0;
        endcase
    end

    // Sequencer: next-state for the FSM and all architectural state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        wd_d    = wd_q;
        cnt_d   = cnt_q;
        rf_we   = 1'b0;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                ir_d    = imem_q[pc_q];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d = regs_q[rs];
                if (ityp && op == 3'b110) b_d = regs_q[rd];
                else if (ityp)            b_d = sext_d;
                else                      b_d = regs_q[rt];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op == 3'b111) begin
                    state_d = S_HALT;
                end else if (op == 3'b110) begin
                    // BEQ when I-type; R-type form retires as a no-op
                    if (ityp && a_q == b_q)
                        pc_d = pc_q + IMEM_AW'(1) + sext_pc;
                    else
                        pc_d = pc_q + IMEM_AW'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_FETCH;
                end else begin
                    res_d   = alu_r;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                wd_d    = res_q;
                rf_we   = (rd != '0);
                pc_d    = pc_q + IMEM_AW'(1);
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers and register file, cleared by async reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            wd_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < RF_N; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            wd_q    <= wd_d;
            cnt_q   <= cnt_d;
            if (rf_we) regs_q[rd] <= res_q;
        end
    end

    // Instruction memory: not reset, loadable only while not running
    always_ff @(posedge clock) begin
        if (imem.imem_we && idle_like)
            imem_q[imem.imem_addr] <= imem.imem_wdata;
    end

    assign dbg_rdata   = (dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];
    assign pc          = pc_q;
    assign ir          = ir_q;
    assign wb_valid    = (state_q == S_WB);
    assign writedata   = wb_valid ? res_q : wd_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                         (state_q == S_EXEC)  || (state_q == S_WB);
    assign halted      = (state_q == S_HALT);
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core at default parameters.
// Instruction-level reference model with per-instruction cycle costs.
module tb_mips_multicycle_core;
    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  dbg_raddr = '0;
    logic [3:0]  dbg_rdata;
    logic [3:0]  pc;
    logic [11:0] ir;
    logic [3:0]  writedata;
    logic        wb_valid, busy, halted;
    logic [15:0] instr_count;

    int vectors = 0;
    int miscompares = 0;

    mips_multicycle_core_if #(.IMEM_AW(4), .INSTR_W(12)) imem_bus ();

    mips_multicycle_core dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .imem        (imem_bus),
        .dbg_raddr   (dbg_raddr),
        .dbg_rdata   (dbg_rdata),
        .pc          (pc),
        .ir          (ir),
        .writedata   (writedata),
        .wb_valid    (wb_valid),
        .busy        (busy),
        .halted      (halted),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    logic [11:0] prog [16];
    logic [11:0] m_mem [16];
    logic [3:0]  m_r [4];
    int          m_pc, m_cnt, m_cyc;
    bit          m_halt;
    logic [3:0]  m_wd [$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input int idx,
                          input logic [3:0] exp);
        dbg_raddr = 2'(idx);
        #1;
        chk(tag, {28'd0, dbg_rdata}, {28'd0, exp});
    endtask

    // ISA-level model: runs from pc 0, costs 4/3/3 cycles
    task automatic model_run(input int max_i);
        logic [11:0] w;
        logic [3:0]  a, b, r, imm;
        logic [1:0]  rd, rs;
        logic        t;
        logic [2:0]  op;
        m_pc = 0; m_cyc = 0; m_halt = 0;
        m_wd.delete();
        for (int k = 0; k < max_i && !m_halt; k++) begin
            w = m_mem[m_pc];
            {t, op, rd, rs, imm} = w;
            a = m_r[rs];
            b = t ? imm : m_r[imm[3:2]];
            r = 4'd0;
            if (op == 3'd7) begin
                m_halt = 1; m_cyc += 3;
            end else if (op == 3'd6) begin
                if (t && m_r[rs] == m_r[rd])
                    m_pc = (m_pc + 1 + int'($signed(imm))) & 15;
                else
                    m_pc = (m_pc + 1) & 15;
                m_cnt++; m_cyc += 3;
            end else begin
                case (op)
                    3'd0: r = a & b;
                    3'd1: r = a + b;
                    3'd2: r = a - b;
                    3'd3: r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
                    3'd4: r = a | b;
                    default: r = a ^ b;
                endcase
                m_wd.push_back(r);
                if (rd != 2'd0) m_r[rd] = r;
                m_pc = (m_pc + 1) & 15;
                m_cnt++; m_cyc += 4;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 4'd0;
        m_cnt = 0;
    endtask

    task automatic load();
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            imem_bus.imem_we    = 1'b1;
            imem_bus.imem_addr  = 4'(i);
            imem_bus.imem_wdata = prog[i];
            m_mem[i] = prog[i];
        end
        @(negedge clock);
        imem_bus.imem_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic run_check(input string tag, input bit poke,
                             input logic [3:0] paddr, output int n);
        logic [3:0] q [$];
        model_run(1000);
        pulse_start();
        n = 0;
        while (!halted && n < 2000) begin
            if (wb_valid) q.push_back(writedata);
            if (poke && n == 5) begin
                start = 1'b1;
                imem_bus.imem_we    = 1'b1;
                imem_bus.imem_addr  = paddr;
                imem_bus.imem_wdata = 12'h951;
            end
            if (n == 6) begin
                start = 1'b0;
                imem_bus.imem_we = 1'b0;
            end
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        imem_bus.imem_we = 1'b0;
        chk({tag, "_cyc"}, n, m_cyc);
        chk({tag, "_nwb"}, q.size(), m_wd.size());
        for (int i = 0; i < q.size() && i < m_wd.size(); i++)
            chk($sformatf("%s_wd%0d", tag, i), {28'd0, q[i]}, {28'd0, m_wd[i]});
        chk({tag, "_pc"}, {28'd0, pc}, m_pc);
        chk({tag, "_cnt"}, {16'd0, instr_count}, m_cnt & 'hFFFF);
        chk({tag, "_halted"}, {31'd0, halted}, 1);
        for (int i = 0; i < 4; i++)
            rd_chk($sformatf("%s_r%0d", tag, i), i, m_r[i]);
    endtask

    task automatic basic_prog();
        for (int i = 0; i < 16; i++) prog[i] = 12'h700;
        prog[0] = 12'h943; prog[1] = 12'h982; prog[2] = 12'h9C5;
        prog[3] = 12'h25B; prog[4] = 12'h4F4; prog[5] = 12'h2F4;
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_pc"}, {28'd0, pc}, 0);
        chk({tag, "_ir"}, {20'd0, ir}, 0);
        chk({tag, "_wd"}, {28'd0, writedata}, 0);
        chk({tag, "_wbv"}, {31'd0, wb_valid}, 0);
        chk({tag, "_busy"}, {31'd0, busy}, 0);
        chk({tag, "_halted"}, {31'd0, halted}, 0);
        chk({tag, "_cnt"}, {16'd0, instr_count}, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        imem_bus.imem_we = 1'b0;
        imem_bus.imem_addr = '0;
        imem_bus.imem_wdata = '0;
        model_reset();

        #3 reset_n = 1'b0;
        #1 zero_chk("rst");
        rd_chk("rst_r1", 1, 4'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        basic_prog();
        load();
        run_check("basic", 1'b1, 4'd6, n);
        chk("basic_27", n, 27);
        chk("basic_cnt6", {16'd0, instr_count}, 6);
        rd_chk("basic_R1", 1, 4'd1);
        rd_chk("basic_R3", 3, 4'd4);

        do_reset();
        for (int i = 0; i < 16; i++) prog[i] = 12'h700;
        prog[0] = 12'h943; prog[1] = 12'h981; prog[2] = 12'h258;
        prog[3] = 12'hE11; prog[4] = 12'hE0D;
        load();
        run_check("loop", 1'b0, 4'd0, n);
        chk("loop_pc5", {28'd0, pc}, 5);
        chk("loop_cnt10", {16'd0, instr_count}, 10);
        rd_chk("loop_R1", 1, 4'd0);

        prog[0] = 12'h907; prog[1] = 12'h700;
        load();
        run_check("zero", 1'b0, 4'd0, n);
        chk("zero_wd7", {28'd0, writedata}, 7);
        rd_chk("zero_R0", 0, 4'd0);

        prog[0] = 12'h98F; prog[1] = 12'h3E0; prog[2] = 12'h700;
        load();
        run_check("sgn", 1'b0, 4'd0, n);
        rd_chk("sgn_R2", 2, 4'hF);
        rd_chk("sgn_R3", 3, 4'd1);

        do_reset();
        for (int i = 0; i < 15; i++) prog[i] = 12'h600;
        prog[15] = 12'h951;
        load();
        model_run(16);
        pulse_start();
        n = 0;
        while (n < m_cyc) begin
            if (n == m_cyc - 1) chk("wrap_pc15", {28'd0, pc}, 15);
            @(negedge clock);
            n++;
        end
        chk("wrap_pc", {28'd0, pc}, m_pc);
        chk("wrap_busy", {31'd0, busy}, 1);
        chk("wrap_cnt", {16'd0, instr_count}, m_cnt);
        rd_chk("wrap_R1", 1, m_r[1]);

        do_reset();
        basic_prog();
        load();
        pulse_start();
        n = 0;
        while (n < 14) begin
            @(negedge clock);
            n++;
        end
        reset_n = 1'b0;
        #1 zero_chk("midrst");
        rd_chk("midrst_R1", 1, 4'd0);
        rd_chk("midrst_R2", 2, 4'd0);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        run_check("rerun", 1'b1, 4'd6, n);
        chk("rerun_27", n, 27);

        for (int r = 0; r < 8; r++) begin
            for (int a = 0; a < 15; a++) begin
                int k;
                int off;
                logic [7:0] f;
                k = $urandom_range(0, 19);
                f = 8'($urandom);
                if (k < 12)
                    prog[a] = {1'($urandom), 3'($urandom_range(0, 5)), f};
                else if (k < 14)
                    prog[a] = {1'b0, 3'b110, f};
                else if (k < 19) begin
                    off = $urandom_range(0, (14 - a) < 7 ? 14 - a : 7);
                    prog[a] = {1'b1, 3'b110, f[7:4], 4'(off)};
                end else
                    prog[a] = {1'b1, 3'b111, f};
            end
            prog[15] = {1'($urandom), 3'b111, 8'($urandom)};
            load();
            run_check($sformatf("rnd%0d", r), 1'b1, 4'd15, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
